grid_link_arbiter: RTL and testbench

- Parametrised N-link successor to the fixed two-port grid_1/grid_2 inter-FPGA link pair.
- Each of NUM_LINKS inbound 64-bit valid/ready streams is buffered in its own FIFO.
- Buffered streams are round-robin arbitrated onto a single registered output stream, tagged with the source link index.
- Provides per-link enable with discard accounting, and a router_busy indicator that holds for a configurable quiet period, for use by the controller's convergence check.

---
 rtl/grid_link_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_grid_link_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_link_arbiter.sv
// rtl/grid_link_arbiter.sv - N-link buffered round-robin stream arbiter with discard accounting
module grid_link_arbiter #(
  parameter int NUM_LINKS            = 2,
  parameter int DATA_WIDTH           = 64,
  parameter int FIFO_DEPTH           = 4,
  parameter int ROUTER_DELAY_COUNTER = 18,
  localparam int CH_W                = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_LINKS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_LINKS-1:0]            in_valid,
  output logic [NUM_LINKS-1:0]            in_ready,
  input  logic [NUM_LINKS-1:0]            link_enable,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [CH_W-1:0]                 out_channel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [15:0]                     drop_count,
  output logic                            router_busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDLE_W = (ROUTER_DELAY_COUNTER > 1) ? $clog2(ROUTER_DELAY_COUNTER + 1) : 1;

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(ROUTER_DELAY_COUNTER);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_LINKS - 1);

  // Per-link FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q    [NUM_LINKS][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [NUM_LINKS];
  logic [PTR_W-1:0]      wr_ptr_d [NUM_LINKS];
  logic [PTR_W-1:0]      rd_ptr_q [NUM_LINKS];
  logic [PTR_W-1:0]      rd_ptr_d [NUM_LINKS];
  logic [CNT_W-1:0]      cnt_q    [NUM_LINKS];
  logic [CNT_W-1:0]      cnt_d    [NUM_LINKS];

  logic [NUM_LINKS-1:0]  full;
  logic [NUM_LINKS-1:0]  empty;
  logic [NUM_LINKS-1:0]  push;
  logic [NUM_LINKS-1:0]  pop;
  logic [NUM_LINKS-1:0]  drop;

  // Arbiter and output register
  logic [CH_W-1:0]       rr_q, rr_d;
  logic [CH_W-1:0]       grant_idx;
  logic                  grant_valid;
  logic                  load;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]       out_channel_q, out_channel_d;
  logic                  out_valid_q, out_valid_d;

  // Discard accounting and quiet-period tracking
  logic [15:0]           drop_count_q, drop_count_d;
  logic [16:0]           drop_sum;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  busy_q, busy_d;
  logic                  active;

  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_valid   = out_valid_q;
  assign drop_count  = drop_count_q;
  assign router_busy = busy_q;

  // Input handshake: full comes from registered occupancy only, disabled links always sink
  always_comb begin
    full     = '0;
    empty    = '0;
    in_ready = '0;
    push     = '0;
    drop     = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      full[i]     = (cnt_q[i] == FULL_CNT);
      empty[i]    = (cnt_q[i] == '0);
      in_ready[i] = link_enable[i] ? !full[i] : 1'b1;
      push[i]     = link_enable[i] & in_valid[i] & !full[i];
      drop[i]     = !link_enable[i] & in_valid[i];
    end
  end

  // Round-robin grant from rr_q upward and output register next state
  always_comb begin
    int idx;
    idx           = 0;
    grant_valid   = 1'b0;
    grant_idx     = '0;
    pop           = '0;
    rr_d          = rr_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    load          = !out_valid_q | out_ready;

    for (int k = 0; k < NUM_LINKS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_LINKS) idx = idx - NUM_LINKS;
      if (!grant_valid && !empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end

    if (load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d    = mem_q[grant_idx][rd_ptr_q[grant_idx]];
        out_channel_d = grant_idx;
        rr_d          = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        for (int i = 0; i < NUM_LINKS; i++) begin
          pop[i] = (grant_idx == CH_W'(i));
        end
      end
    end
  end

  // FIFO pointer and occupancy next state; push+pop together leaves occupancy unchanged
  always_comb begin
    for (int i = 0; i < NUM_LINKS; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Saturating popcount of discarded beats, plus quiet-period counter
  always_comb begin
    drop_sum = {1'b0, drop_count_q};
    for (int i = 0; i < NUM_LINKS; i++) begin
      drop_sum = drop_sum + {16'd0, drop[i]};
    end
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    active = (|(~empty)) | out_valid_q | (|push);
    if (active) begin
      idle_d = IDLE_LOAD;
    end else if (idle_q != '0) begin
      idle_d = idle_q - 1'b1;
    end else begin
      idle_d = idle_q;
    end
    busy_d = active | (idle_d != '0);
  end

  // FIFO payload storage, written on accepted beats only
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State registers with asynchronous reset that discards all buffered beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_q          <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      drop_count_q  <= '0;
      idle_q        <= '0;
      busy_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_q          <= rr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      drop_count_q  <= drop_count_d;
      idle_q        <= idle_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_grid_link_arbiter.sv
// tb/tb_grid_link_arbiter.sv - scoreboard bench for grid_link_arbiter
module tb_grid_link_arbiter;

  localparam int NL  = 4;
  localparam int DW  = 64;
  localparam int FD  = 4;
  localparam int RD  = 18;
  localparam int CHW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NL*DW-1:0] in_data;
  logic [NL-1:0]    in_valid;
  logic [NL-1:0]    in_ready;
  logic [NL-1:0]    link_enable;
  logic [DW-1:0]    out_data;
  logic [CHW-1:0]   out_channel;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      drop_count;
  logic             router_busy;

  int tests = 0;
  int fails = 0;
  int out_beats = 0;
  int model_drops = 0;
  logic [DW-1:0] exp_q [NL][$];
  logic [DW-1:0] mon_exp;

  grid_link_arbiter #(
    .NUM_LINKS(NL), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ROUTER_DELAY_COUNTER(RD)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .link_enable(link_enable), .out_data(out_data),
    .out_channel(out_channel), .out_valid(out_valid), .out_ready(out_ready),
    .drop_count(drop_count), .router_busy(router_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input int link, input int n);
    return {8'(link), 24'(n), 32'($urandom)};
  endfunction

  task automatic set_data(input int link, input logic [63:0] v);
    in_data[link*DW +: DW] = v;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NL; i++) s += exp_q[i].size();
    return s;
  endfunction

  // Scoreboard monitor: accepted beats become expectations, output beats consume them
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NL; i++) exp_q[i].delete();
      model_drops = 0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (in_valid[i]) begin
          if (link_enable[i]) begin
            if (in_ready[i]) exp_q[i].push_back(in_data[i*DW +: DW]);
          end else begin
            model_drops++;
            check("ready_when_disabled", 64'(in_ready[i]), 64'd1);
          end
        end
      end
      if (out_valid && out_ready) begin
        out_beats++;
        if (exp_q[out_channel].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got ch %0d data %h required no beat", out_channel, out_data);
        end else begin
          mon_exp = exp_q[out_channel].pop_front();
          check("payload", out_data, mon_exp);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    link_enable = '1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_valid = '0;
    out_ready = 1'b1;
    while ((pending() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL %s_drain: got %0d beats pending required 0", name, pending());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int b0;
    logic [63:0] first;

    reset = 1'b0;
    in_data = '0;
    in_valid = '0;
    out_ready = 1'b0;
    link_enable = '1;
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_channel", 64'(out_channel), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_router_busy", 64'(router_busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'hF);
    do_reset();

    // Single beat latency and quiet period
    set_data(1, 64'hDEAD_BEEF);
    in_valid = 4'b0010;
    out_ready = 1'b1;
    tick();
    in_valid = '0;
    tick();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", out_data, 64'hDEAD_BEEF);
    check("single_channel", 64'(out_channel), 64'd1);
    check("single_busy", 64'(router_busy), 64'd1);
    tick();
    check("single_valid_drop", 64'(out_valid), 64'd0);
    repeat (RD - 1) tick();
    check("busy_before_quiet_end", 64'(router_busy), 64'd1);
    tick();
    check("busy_after_quiet_end", 64'(router_busy), 64'd0);

    // Round-robin over preloaded links
    do_reset();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < NL; i++) set_data(i, mk(i, b));
      in_valid = 4'hF;
      tick();
    end
    in_valid = '0;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("rr_valid", 64'(out_valid), 64'd1);
      check("rr_channel", 64'(out_channel), 64'(k % NL));
      tick();
    end
    check("rr_done", 64'(out_valid), 64'd0);

    // Backpressure until full, then drain
    do_reset();
    acc = 0;
    first = mk(0, 0);
    set_data(0, first);
    in_valid = 4'b0001;
    for (int c = 0; c < 20 && in_ready[0]; c++) begin
      tick();
      acc++;
      set_data(0, mk(0, acc));
    end
    check("bp_accepted", 64'(acc), 64'(FD + 1));
    check("bp_in_ready_low", 64'(in_ready[0]), 64'd0);
    repeat (3) begin
      tick();
      check("bp_hold_data", out_data, first);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    b0 = out_beats;
    drain("bp");
    check("bp_drained", 64'(out_beats - b0), 64'(FD + 1));

    // Discard on disabled link, buffered entries survive disable
    do_reset();
    link_enable = 4'b0001;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_data(0, mk(0, c));
      set_data(1, mk(1, c));
      in_valid = 4'b0011;
      tick();
    end
    in_valid = '0;
    tick();
    check("discard_count", 64'(drop_count), 64'd10);
    drain("discard");
    out_ready = 1'b0;
    link_enable = 4'hF;
    for (int c = 0; c < 4; c++) begin
      set_data(0, mk(0, 100 + c));
      in_valid = 4'b0001;
      tick();
    end
    in_valid = '0;
    link_enable = 4'b1110;
    b0 = out_beats;
    drain("disabled_buffered");
    check("disabled_buffered_beats", 64'(out_beats - b0), 64'd4);
    check("discard_count_hold", 64'(drop_count), 64'd10);

    // Simultaneous drops and saturation
    do_reset();
    link_enable = 4'b0011;
    in_valid = 4'b1100;
    repeat (100) tick();
    check("drop_popcount", 64'(drop_count), 64'd200);
    repeat (32800) tick();
    check("drop_saturate", 64'(drop_count), 64'hFFFF);
    repeat (20) tick();
    check("drop_saturate_hold", 64'(drop_count), 64'hFFFF);
    in_valid = '0;

    // Push and pop together at occupancy 2
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_data(0, mk(0, c));
      in_valid = 4'b0001;
      tick();
    end
    out_ready = 1'b1;
    for (int c = 3; c < 8; c++) begin
      set_data(0, mk(0, c));
      tick();
    end
    in_valid = '0;
    out_ready = 1'b0;
    acc = 0;
    set_data(0, mk(0, 50));
    in_valid = 4'b0001;
    for (int c = 0; c < 10 && in_ready[0]; c++) begin
      tick();
      acc++;
      set_data(0, mk(0, 50 + acc));
    end
    check("occupancy_room", 64'(acc), 64'(FD - 2));
    drain("occupancy");

    // Asynchronous reset mid-operation
    do_reset();
    link_enable = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      set_data(0, mk(0, c));
      set_data(3, mk(3, c));
      in_valid = 4'b1001;
      tick();
    end
    in_valid = '0;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    check("pre_reset_drops", 64'(drop_count), 64'd4);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_busy", 64'(router_busy), 64'd0);
    check("async_rst_drops", 64'(drop_count), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    link_enable = 4'hF;
    out_ready = 1'b1;
    b0 = out_beats;
    repeat (10) tick();
    check("no_stale_beat", 64'(out_beats - b0), 64'd0);

    // Randomized traffic against scoreboard and drop model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (c % 50 == 0) link_enable = NL'($urandom);
      for (int i = 0; i < NL; i++) set_data(i, mk(i, c));
      in_valid = NL'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = '0;
    tick();
    check("random_drops", 64'(drop_count), 64'((model_drops > 65535) ? 65535 : model_drops));
    drain("random");
    check("random_pending", 64'(pending()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
